abl_seq: RTL
============

Name: abl_seq

Overview:
- Addressing-mode sequencer for the address-bus-low datapath.
- Accepts an addressing-mode request from microcode and drives the datapath controls cycle by cycle: op, CI, cond, ld_ahl, ld_pc, inc_pc.
- Watches the datapath carry-out to insert a page-fix cycle and tells the address-high logic how to adjust.
- Sits between the microcode decoder and the ABL/ABH datapaths.

Parameters:
- none. All mode and op encodings live in abl_pkg.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global ready; all state advance is gated by rdy=1
- start  in  1  request a mode sequence; sampled only in IDLE with rdy=1
- mode  in  3  0 ZP, 1 ZPX, 2 ABS, 3 ABSX, 4 BRANCH, 5 PULL, 6 RESTORE, 7 reserved (treated as RESTORE)
- fix_always  in  1  force FIX cycle for ABSX (writes/RMW)
- seq  in  1  in IDLE: advance PC (sequential fetch)
- taken  in  1  branch condition, valid in BRANCH T1
- DB  in  8  data bus; only DB[7] is used (branch offset sign)
- CO  in  1  carry out from the ABL datapath, same cycle
- op  out  4  datapath operation
- CI  out  1  datapath carry in
- cond  out  1  datapath cond; selects DB as base when op[3:2]=11
- ld_ahl  out  1  load address hold register
- ld_pc  out  1  load PCL
- inc_pc  out  1  increment on PCL load
- abh_adj  out  2  high-byte adjust during FIX: 00 none, 01 +1, 11 -1
- busy  out  1  state != IDLE
- done  out  1  final address cycle of the sequence

Behaviour:
- Datapath op semantics:
  - op[3:2] selects base: 00 zero, 01 PCL, 10 AHL, 11 DB if cond else zero.
  - op[1:0] selects the sum: 00 REG+CI, 01 base+REG+CI, 10 base+CI, 11 base+ABL+CI.
- States: IDLE, T1, T2, FIX.
  - Registers: 2-bit state, latched mode (3), fix_always (1), co_q (1), sign_q (1).
  - All outputs are combinational decode of the registered state/latches plus taken/CO.
- Reset (async, rst_n=0): state=IDLE, latches=0. Outputs immediately take IDLE values: op=0011, CI=seq, ld_pc=inc_pc=seq, all others 0.
- IDLE:
  - Drives op=0011, CI=seq, ld_pc=inc_pc=seq.
  - start&rdy latches mode/fix_always and moves to T1 next cycle (latency 1). busy=1 from T1.
- ZP T1: op=1110, cond=1, CI=0 (ADL=DB), ld_pc=inc_pc=1, done -> IDLE.
- ZPX T1: op=1101, cond=1, CI=0 (ADL=DB+REG), ld_pc=inc_pc=1, done. CO ignored (zero-page wrap).
- ABS:
  - T1: op=0011, CI=1, ld_ahl=1, ld_pc=inc_pc=1 -> T2.
  - T2: op=1010, CI=0 (ADL=AHL), ld_pc=inc_pc=1, done.
- ABSX:
  - T1: same as ABS.
  - T2: op=1001, CI=0 (ADL=AHL+REG), ld_pc=inc_pc=1, co_q<=CO.
    - If CO|fix_always -> FIX.
    - Else done -> IDLE.
  - FIX: op=0011, CI=0 (hold ABL), abh_adj = co_q?01:00, done.
- BRANCH T1: cond=taken, op=1111, CI=1, ld_pc=inc_pc=1.
  - Not taken: ADL=ABL+1, done.
  - Taken: ADL=DB+ABL+1; sign_q<=DB[7], co_q<=CO.
    - CO!=DB[7] -> FIX, no done.
    - Else done.
  - FIX: op=0011, CI=0, abh_adj = co_q?01:11, done.
- PULL T1: op=0000, CI=1 (ADL=REG+1), done.
- RESTORE T1: op=0110, CI=0 (ADL=PCL), done.
- rdy=0: state and latches hold; outputs stay stable; done and abh_adj persist until the rdy=1 cycle.
- Handshake and boundaries:
  - start outside IDLE is ignored; no queueing.
  - The done cycle always returns to IDLE. Back-to-back requests cost one IDLE cycle.
  - rst_n low mid-sequence aborts to IDLE with no pending done.
  - ld_ahl is never asserted except in ABS/ABSX T1.

Decomposition:
- abl_pkg: mode codes, op constants (OP_NEXT=0011, OP_DB=1110, OP_DBREG=1101, OP_AHL=1010, OP_AHLREG=1001, OP_BRANCH=1111, OP_PULL=0000, OP_PCL=0110), abh_adj codes, state enum.
- One natural sub-module: abl_seq_decode, the combinational output decode from state/mode/taken/co_q/sign_q.

Test Plan:
- ABSX, operand low 0x20, REG=0xF0, fix_always=0 -> T2 op=1001, CO=1; FIX abh_adj=01, done in FIX; busy for 3 cycles.
- ABSX, REG=0x10, fix_always=0 -> CO=0, done in T2, no FIX.
- ABSX, REG=0x10, fix_always=1 -> FIX, abh_adj=00.
- BRANCH taken, ABL=0x10, DB=0x80 -> ADL=0x91, CO=0, sign=1 -> FIX abh_adj=11.
- BRANCH taken, ABL=0xF0, DB=0x20 -> CO=1, sign=0 -> FIX abh_adj=01.
- BRANCH not taken -> op=1111, cond=0, ADL=ABL+1, done in T1.
- ABS with rdy=0 for 3 cycles in T2 -> op=1010 and done held stable; completes the cycle after rdy returns.
- rst_n=0 asynchronously during FIX -> same-cycle busy=0, done=0, op=0011, abh_adj=00; start then accepted normally.

Source files
------------

// File: rtl/abl_seq_pkg.sv
// abl_pkg: shared encodings for the address-bus-low sequencer.
// Holds the mode codes, datapath op codes, high-byte adjust codes and FSM states.
package abl_pkg;
    typedef enum logic [2:0] {
        M_ZP, M_ZPX, M_ABS, M_ABSX, M_BRANCH, M_PULL, M_RESTORE, M_RSVD
    } mode_e;
    typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_FIX} state_e;
    // op[3:2] picks the base (zero/PCL/AHL/DB-if-cond), op[1:0] picks the sum form
    localparam logic [3:0] OP_NEXT   = 4'b0011;
    localparam logic [3:0] OP_DB     = 4'b1110;
    localparam logic [3:0] OP_DBREG  = 4'b1101;
    localparam logic [3:0] OP_AHL    = 4'b1010;
    localparam logic [3:0] OP_AHLREG = 4'b1001;
    localparam logic [3:0] OP_BRANCH = 4'b1111;
    localparam logic [3:0] OP_PULL   = 4'b0000;
    localparam logic [3:0] OP_PCL    = 4'b0110;
    localparam logic [1:0] ADJ_NONE  = 2'b00;
    localparam logic [1:0] ADJ_INC   = 2'b01;
    localparam logic [1:0] ADJ_DEC   = 2'b11;
endpackage

// File: rtl/abl_seq_if.sv
// abl_seq_if: microcode request and ABL/ABH datapath signals of the sequencer.
// slave: the sequencer (takes rdy/start/mode/fix_always/seq/taken/DB/CO,
//        drives op/CI/cond/ld_ahl/ld_pc/inc_pc/abh_adj/busy/done).
// master: the surrounding decoder/datapath, the opposite directions.
interface abl_seq_if;
    logic       rdy;
    logic       start;
    logic [2:0] mode;
    logic       fix_always;
    logic       seq;
    logic       taken;
    logic [7:0] DB;
    logic       CO;
    logic [3:0] op;
    logic       CI;
    logic       cond;
    logic       ld_ahl;
    logic       ld_pc;
    logic       inc_pc;
    logic [1:0] abh_adj;
    logic       busy;
    logic       done;
    modport slave (
        input  rdy, start, mode, fix_always, seq, taken, DB, CO,
        output op, CI, cond, ld_ahl, ld_pc, inc_pc, abh_adj, busy, done
    );
    modport master (
        output rdy, start, mode, fix_always, seq, taken, DB, CO,
        input  op, CI, cond, ld_ahl, ld_pc, inc_pc, abh_adj, busy, done
    );
endinterface

// File: rtl/abl_seq_decode.sv
// abl_seq_decode: combinational datapath-control decode for the ABL sequencer.
// Inputs: state, latched mode/fix_q/co_q/sign_q, live seq/taken/co/db7.
// Outputs: op, ci, cond, ld_ahl, ld_pc, inc_pc, abh_adj, busy, done.
module abl_seq_decode
    import abl_pkg::*;
(
    input  state_e     state,
    input  mode_e      mode,
    input  logic       fix_q,
    input  logic       co_q,
    input  logic       sign_q,
    input  logic       seq,
    input  logic       taken,
    input  logic       co,
    input  logic       db7,
    output logic [3:0] op,
    output logic       ci,
    output logic       cond,
    output logic       ld_ahl,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic [1:0] abh_adj,
    output logic       busy,
    output logic       done
);
    always_comb begin
        op      = OP_NEXT;
        ci      = 1'b0;
        cond    = 1'b0;
        ld_ahl  = 1'b0;
        ld_pc   = 1'b0;
        inc_pc  = 1'b0;
        abh_adj = ADJ_NONE;
        busy    = state != S_IDLE;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                ci     = seq;
                ld_pc  = seq;
                inc_pc = seq;
            end
            S_T1: case (mode)
                M_ZP, M_ZPX: begin
                    op     = mode == M_ZP ? OP_DB : OP_DBREG;
                    cond   = 1'b1;
                    ld_pc  = 1'b1;
                    inc_pc = 1'b1;
                    done   = 1'b1;
                end
                M_ABS, M_ABSX: begin
                    ci     = 1'b1;
                    ld_ahl = 1'b1;
                    ld_pc  = 1'b1;
                    inc_pc = 1'b1;
                end
                M_BRANCH: begin
                    op     = OP_BRANCH;
                    cond   = taken;
                    ci     = 1'b1;
                    ld_pc  = 1'b1;
                    inc_pc = 1'b1;
                    // a page is crossed when the carry disagrees with the offset sign
                    done   = !taken || (co == db7);
                end
                M_PULL: begin
                    op   = OP_PULL;
                    ci   = 1'b1;
                    done = 1'b1;
                end
                default: begin
                    op   = OP_PCL;
                    done = 1'b1;
                end
            endcase
            S_T2: begin
                op     = mode == M_ABSX ? OP_AHLREG : OP_AHL;
                ld_pc  = 1'b1;
                inc_pc = 1'b1;
                done   = mode != M_ABSX || !(co || fix_q);
            end
            S_FIX: begin
                done    = 1'b1;
                // branch FIX is only entered with co_q != sign_q
                abh_adj = mode == M_BRANCH
                        ? (co_q && !sign_q ? ADJ_INC : sign_q && !co_q ? ADJ_DEC : ADJ_NONE)
                        : (co_q ? ADJ_INC : ADJ_NONE);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/abl_seq.sv
// abl_seq: addressing-mode sequencer driving the ABL datapath cycle by cycle.
// Ports: clk, rst_n (async active-low), b (abl_seq_if.slave: request, datapath
// controls, CO/DB feedback, busy/done status).
module abl_seq
    import abl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    abl_seq_if.slave  b
);
    state_e state, state_n;
    mode_e  mode_q;
    logic   fix_q, co_q, sign_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mode_q <= M_ZP;
            fix_q  <= 1'b0;
            co_q   <= 1'b0;
            sign_q <= 1'b0;
        end else if (b.rdy) begin
            state <= state_n;
            if (state == S_IDLE && b.start) begin
                mode_q <= mode_e'(b.mode);
                fix_q  <= b.fix_always;
            end
            if (state == S_T1 && mode_q == M_BRANCH && b.taken) begin
                sign_q <= b.DB[7];
                co_q   <= b.CO;
            end
            if (state == S_T2 && mode_q == M_ABSX)
                co_q <= b.CO;
        end
    end
    always_comb begin
        state_n = S_IDLE;
        case (state)
            S_IDLE: state_n = b.start ? S_T1 : S_IDLE;
            S_T1: state_n = (mode_q == M_ABS || mode_q == M_ABSX) ? S_T2
                          : (mode_q == M_BRANCH && b.taken && b.CO != b.DB[7]) ? S_FIX : S_IDLE;
            S_T2: state_n = (mode_q == M_ABSX && (b.CO || fix_q)) ? S_FIX : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
    abl_seq_decode u_decode (
        .state   (state),
        .mode    (mode_q),
        .fix_q   (fix_q),
        .co_q    (co_q),
        .sign_q  (sign_q),
        .seq     (b.seq),
        .taken   (b.taken),
        .co      (b.CO),
        .db7     (b.DB[7]),
        .op      (b.op),
        .ci      (b.CI),
        .cond    (b.cond),
        .ld_ahl  (b.ld_ahl),
        .ld_pc   (b.ld_pc),
        .inc_pc  (b.inc_pc),
        .abh_adj (b.abh_adj),
        .busy    (b.busy),
        .done    (b.done)
    );
endmodule
